// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB.
// Ports: EX bundle in, stall/load-hazard out, RAM ready handshake, registered WB bundle out.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] result,
    input  logic        reg_write_en,
    input  logic [4:0]  reg_write_addr,
    input  logic [31:0] current_pc_addr,
    output logic        stall_req,
    output logic        mem_load_flag,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic        ram_ready,
    input  logic [31:0] ram_read_data,
    output logic [31:0] wb_result,
    output logic        wb_reg_write_en,
    output logic [4:0]  wb_reg_write_addr,
    output logic [31:0] wb_current_pc_addr
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic        req_sign;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_data;
    logic [4:0]  req_waddr;
    logic [31:0] req_pc;

    logic        mem_op;
    logic        busy;
    logic [31:0] load_data;

    function automatic logic [31:0] replicate(input logic [31:0] d,
                                              input logic [3:0]  s);
        case (s)
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: replicate = {4{d[7:0]}};
            4'b0011, 4'b1100: replicate = {2{d[15:0]}};
            default:          replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [3:0]  s,
                                            input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[7:0];
        h = w[15:0];
        case (s)
            4'b0001: extract = {{24{sx & w[7]}},  w[7:0]};
            4'b0010: begin b = w[15:8];  extract = {{24{sx & b[7]}}, b}; end
            4'b0100: begin b = w[23:16]; extract = {{24{sx & b[7]}}, b}; end
            4'b1000: begin b = w[31:24]; extract = {{24{sx & b[7]}}, b}; end
            4'b0011: extract = {{16{sx & h[15]}}, h};
            4'b1100: begin h = w[31:16]; extract = {{16{sx & h[15]}}, h}; end
            default: extract = w;
        endcase
    endfunction

    assign mem_op    = mem_read_flag | mem_write_flag;
    assign busy      = (state == BUSY);
    assign load_data = extract(ram_read_data, req_sel, req_sign);

    // Gated with rst so the outputs read 0 while reset is held even if
    // upstream still presents a memory op.
    assign stall_req     = rst & ((!busy & mem_op) | (busy & !ram_ready));
    assign mem_load_flag = rst & ((!busy & mem_read_flag) | (busy & req_read));

    // RAM side is driven only from request registers: stable across waits.
    assign ram_en         = busy;
    assign ram_write_en   = (busy & req_write) ? req_sel : 4'b0000;
    assign ram_addr       = {req_addr[31:2], 2'b00};
    assign ram_write_data = req_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            req_addr           <= '0;
            req_sel            <= '0;
            req_sign           <= 1'b0;
            req_read           <= 1'b0;
            req_write          <= 1'b0;
            req_data           <= '0;
            req_waddr          <= '0;
            req_pc             <= '0;
            wb_result          <= '0;
            wb_reg_write_en    <= 1'b0;
            wb_reg_write_addr  <= '0;
            wb_current_pc_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state           <= BUSY;
                        req_addr        <= result;
                        req_sel         <= mem_sel;
                        req_sign        <= mem_sign_ext_flag;
                        // read+write together behaves as a store
                        req_write       <= mem_write_flag;
                        req_read        <= mem_read_flag & !mem_write_flag;
                        req_data        <= replicate(mem_write_data, mem_sel);
                        req_waddr       <= reg_write_addr;
                        req_pc          <= current_pc_addr;
                        wb_reg_write_en <= 1'b0;
                    end else begin
                        wb_result          <= result;
                        wb_reg_write_en    <= reg_write_en;
                        wb_reg_write_addr  <= reg_write_addr;
                        wb_current_pc_addr <= current_pc_addr;
                    end
                end
                BUSY: begin
                    if (ram_ready) begin
                        state              <= IDLE;
                        wb_result          <= req_read ? load_data : req_addr;
                        wb_reg_write_en    <= req_read;
                        wb_reg_write_addr  <= req_waddr;
                        wb_current_pc_addr <= req_pc;
                    end else begin
                        wb_reg_write_en <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
